// File: rtl/dcache_masked_sram_if.sv
// Single read/write port bundle of the DCache lane-masked SRAM macro model.
// The master drives the request side; the slave returns the registered read data.
interface dcache_masked_sram_if #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LANES  = 4,
  parameter int LANE_W = 22,
  parameter int WIDTH  = LANES * LANE_W
);
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [WIDTH-1:0]  RW0_wdata;
  logic [LANES-1:0]  RW0_wmask;
  logic [WIDTH-1:0]  RW0_rdata;

  modport master (
    output RW0_addr, RW0_en, RW0_wmode, RW0_wdata, RW0_wmask,
    input  RW0_rdata
  );

  modport slave (
    input  RW0_addr, RW0_en, RW0_wmode, RW0_wdata, RW0_wmask,
    output RW0_rdata
  );
endinterface

// File: rtl/dcache_masked_sram.sv
// Single-port lane-masked SRAM model for the DCache tag and data arrays, one sub-RAM per lane.
// Optional: DCACHE_SRAM_ZERO_INIT_EN zero-initialises every ram element and the read register.
`ifdef DCACHE_SRAM_ZERO_INIT_EN
  `define DCACHE_SRAM_RAM_INIT = '{default: '0}
  `define DCACHE_SRAM_RDATA_INIT = '0
`else
  `define DCACHE_SRAM_RAM_INIT
  `define DCACHE_SRAM_RDATA_INIT
`endif

// One lane's storage lives in a named scope mem_0_<n> so warmup logic can reach
// <inst>.mem_0_<n>.ram[row] directly; lanes at or above LANES are not elaborated.
`define DCACHE_SRAM_LANE(n, lane_name) \
  if ((n) < LANES) begin : lane_name \
    logic [LANE_W-1:0] ram [0:DEPTH-1] `DCACHE_SRAM_RAM_INIT; \
    always_ff @(posedge RW0_clk) begin \
      if (wr_fire && rw0.RW0_wmask[n]) begin \
        ram[rw0.RW0_addr] <= rw0.RW0_wdata[(n)*LANE_W +: LANE_W]; \
      end \
    end \
    assign rd_word[(n)*LANE_W +: LANE_W] = ram[rw0.RW0_addr]; \
  end

module dcache_masked_sram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LANES  = 4,
  parameter int LANE_W = 22,
  parameter int WIDTH  = LANES * LANE_W
) (
  input  logic                 RW0_clk,
  input  logic                 reset,
  dcache_masked_sram_if.slave  rw0
);

  logic             wr_fire;
  logic             rd_fire;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rdata_q `DCACHE_SRAM_RDATA_INIT;

  // Reset only gates accesses; it never touches the arrays.
  assign wr_fire = !reset && rw0.RW0_en &&  rw0.RW0_wmode;
  assign rd_fire = !reset && rw0.RW0_en && !rw0.RW0_wmode;

  // NOTE: the arrays get no reset branch on purpose: clearing them would destroy
  // preloaded warmup state and would stop them mapping onto plain SRAM macros.
  `DCACHE_SRAM_LANE(0, mem_0_0)
  `DCACHE_SRAM_LANE(1, mem_0_1)
  `DCACHE_SRAM_LANE(2, mem_0_2)
  `DCACHE_SRAM_LANE(3, mem_0_3)
  `DCACHE_SRAM_LANE(4, mem_0_4)
  `DCACHE_SRAM_LANE(5, mem_0_5)
  `DCACHE_SRAM_LANE(6, mem_0_6)
  `DCACHE_SRAM_LANE(7, mem_0_7)
  `DCACHE_SRAM_LANE(8, mem_0_8)
  `DCACHE_SRAM_LANE(9, mem_0_9)
  `DCACHE_SRAM_LANE(10, mem_0_10)
  `DCACHE_SRAM_LANE(11, mem_0_11)
  `DCACHE_SRAM_LANE(12, mem_0_12)
  `DCACHE_SRAM_LANE(13, mem_0_13)
  `DCACHE_SRAM_LANE(14, mem_0_14)
  `DCACHE_SRAM_LANE(15, mem_0_15)
  `DCACHE_SRAM_LANE(16, mem_0_16)
  `DCACHE_SRAM_LANE(17, mem_0_17)
  `DCACHE_SRAM_LANE(18, mem_0_18)
  `DCACHE_SRAM_LANE(19, mem_0_19)
  `DCACHE_SRAM_LANE(20, mem_0_20)
  `DCACHE_SRAM_LANE(21, mem_0_21)
  `DCACHE_SRAM_LANE(22, mem_0_22)
  `DCACHE_SRAM_LANE(23, mem_0_23)
  `DCACHE_SRAM_LANE(24, mem_0_24)
  `DCACHE_SRAM_LANE(25, mem_0_25)
  `DCACHE_SRAM_LANE(26, mem_0_26)
  `DCACHE_SRAM_LANE(27, mem_0_27)
  `DCACHE_SRAM_LANE(28, mem_0_28)
  `DCACHE_SRAM_LANE(29, mem_0_29)
  `DCACHE_SRAM_LANE(30, mem_0_30)
  `DCACHE_SRAM_LANE(31, mem_0_31)

  // NOTE: non-blocking updates keep the read register sampling the array contents
  // from before this edge, which gives read-before-write ordering for free.
  always_ff @(posedge RW0_clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rd_fire) begin
      rdata_q <= rd_word;
    end
  end

  assign rw0.RW0_rdata = rdata_q;

endmodule

`undef DCACHE_SRAM_LANE
`undef DCACHE_SRAM_RAM_INIT
`undef DCACHE_SRAM_RDATA_INIT

// File: tb/tb_dcache_masked_sram.sv
// Directed bench for dcache_masked_sram: a tag-array and a data-array instance share one clock.
// Expected values are hand-computed constants.
module tb_dcache_masked_sram;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  dcache_masked_sram_if #(.DEPTH(64),  .LANES(4),  .LANE_W(22)) tag_bus ();
  dcache_masked_sram_if #(.DEPTH(512), .LANES(32), .LANE_W(8))  data_bus ();

  dcache_masked_sram #(.DEPTH(64), .LANES(4), .LANE_W(22)) dut_tag (
    .RW0_clk (clk),
    .reset   (reset),
    .rw0     (tag_bus.slave)
  );

  dcache_masked_sram #(.DEPTH(512), .LANES(32), .LANE_W(8)) dut_data (
    .RW0_clk (clk),
    .reset   (reset),
    .rw0     (data_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [87:0] ROW5_FULL   = {22'h3, 22'h2, 22'h1, 22'h3FFFFF};
  localparam logic [87:0] ROW5_MASKED = {22'h3, 22'h2, 22'h0ABCDE, 22'h3FFFFF};

  // One clock of tag-port stimulus; outputs are sampled 1 time unit after the edge.
  task automatic tag_cycle(input logic en, input logic wmode, input logic [5:0] addr,
                           input logic [87:0] wdata, input logic [3:0] wmask);
    tag_bus.RW0_en    = en;
    tag_bus.RW0_wmode = wmode;
    tag_bus.RW0_addr  = addr;
    tag_bus.RW0_wdata = wdata;
    tag_bus.RW0_wmask = wmask;
    @(posedge clk);
    #1;
    tag_bus.RW0_en = 1'b0;
  endtask

  task automatic data_cycle(input logic en, input logic wmode, input logic [8:0] addr,
                            input logic [255:0] wdata, input logic [31:0] wmask);
    data_bus.RW0_en    = en;
    data_bus.RW0_wmode = wmode;
    data_bus.RW0_addr  = addr;
    data_bus.RW0_wdata = wdata;
    data_bus.RW0_wmask = wmask;
    @(posedge clk);
    #1;
    data_bus.RW0_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (tag_bus.RW0_rdata !== 88'h0) begin
      failures++;
      $display("FAIL reset_tag_rdata got=%h exp=%h", tag_bus.RW0_rdata, 88'h0);
    end
    checks++;
    if (data_bus.RW0_rdata !== 256'h0) begin
      failures++;
      $display("FAIL reset_data_rdata got=%h exp=0", data_bus.RW0_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_full_write;
    tag_cycle(1'b1, 1'b1, 6'd5, ROW5_FULL, 4'hF);
    checks++;
    if (tag_bus.RW0_rdata !== 88'h0) begin
      failures++;
      $display("FAIL no_write_through got=%h exp=%h", tag_bus.RW0_rdata, 88'h0);
    end
    tag_cycle(1'b1, 1'b0, 6'd5, '0, 4'h0);
    checks++;
    if (tag_bus.RW0_rdata !== ROW5_FULL) begin
      failures++;
      $display("FAIL full_write_read got=%h exp=%h", tag_bus.RW0_rdata, ROW5_FULL);
    end
  endtask

  task automatic test_masked_write;
    tag_cycle(1'b1, 1'b1, 6'd5, {22'h111111, 22'h111111, 22'h0ABCDE, 22'h111111}, 4'b0010);
    tag_cycle(1'b1, 1'b0, 6'd5, '0, 4'h0);
    checks++;
    if (tag_bus.RW0_rdata !== ROW5_MASKED) begin
      failures++;
      $display("FAIL masked_write got=%h exp=%h", tag_bus.RW0_rdata, ROW5_MASKED);
    end
    // All-zero mask must be a no-op.
    tag_cycle(1'b1, 1'b1, 6'd5, {88{1'b1}}, 4'b0000);
    tag_cycle(1'b1, 1'b0, 6'd5, '0, 4'h0);
    checks++;
    if (tag_bus.RW0_rdata !== ROW5_MASKED) begin
      failures++;
      $display("FAIL zero_mask_noop got=%h exp=%h", tag_bus.RW0_rdata, ROW5_MASKED);
    end
  endtask

  task automatic test_backdoor;
    for (int i = 0; i < 10; i++) begin
      dut_tag.mem_0_2.ram[63] = 22'h155555;
      tag_cycle(1'b0, 1'b0, 6'd0, '0, 4'h0);
    end
    tag_cycle(1'b1, 1'b0, 6'd63, '0, 4'h0);
    checks++;
    if (tag_bus.RW0_rdata[44 +: 22] !== 22'h155555) begin
      failures++;
      $display("FAIL backdoor_read got=%h exp=%h", tag_bus.RW0_rdata[44 +: 22], 22'h155555);
    end
    tag_cycle(1'b1, 1'b1, 6'd63, {22'h0, 22'h0F0F0F, 22'h0, 22'h0}, 4'b0100);
    tag_cycle(1'b1, 1'b0, 6'd63, '0, 4'h0);
    checks++;
    if (tag_bus.RW0_rdata[44 +: 22] !== 22'h0F0F0F) begin
      failures++;
      $display("FAIL backdoor_overwrite got=%h exp=%h", tag_bus.RW0_rdata[44 +: 22], 22'h0F0F0F);
    end
  endtask

  task automatic test_back_to_back;
    // Read row 5, then overwrite lane 0 on the very next edge.
    tag_cycle(1'b1, 1'b0, 6'd5, '0, 4'h0);
    tag_cycle(1'b1, 1'b1, 6'd5, {66'h0, 22'h00C0DE}, 4'b0001);
    checks++;
    if (tag_bus.RW0_rdata !== ROW5_MASKED) begin
      failures++;
      $display("FAIL read_before_write got=%h exp=%h", tag_bus.RW0_rdata, ROW5_MASKED);
    end
    tag_cycle(1'b1, 1'b0, 6'd5, '0, 4'h0);
    checks++;
    if (tag_bus.RW0_rdata !== {22'h3, 22'h2, 22'h0ABCDE, 22'h00C0DE}) begin
      failures++;
      $display("FAIL read_after_write got=%h exp=%h", tag_bus.RW0_rdata,
               {22'h3, 22'h2, 22'h0ABCDE, 22'h00C0DE});
    end
  endtask

  task automatic test_hold_and_reset;
    logic [87:0] row5;
    row5 = {22'h3, 22'h2, 22'h0ABCDE, 22'h00C0DE};
    repeat (3) tag_cycle(1'b0, 1'b0, 6'd7, '0, 4'h0);
    checks++;
    if (tag_bus.RW0_rdata !== row5) begin
      failures++;
      $display("FAIL idle_hold got=%h exp=%h", tag_bus.RW0_rdata, row5);
    end
    tag_cycle(1'b1, 1'b1, 6'd9, {88{1'b1}}, 4'hF);
    checks++;
    if (tag_bus.RW0_rdata !== row5) begin
      failures++;
      $display("FAIL write_hold got=%h exp=%h", tag_bus.RW0_rdata, row5);
    end
    // Accesses during reset must be ignored.
    reset = 1'b1;
    tag_cycle(1'b1, 1'b1, 6'd5, 88'h0, 4'hF);
    tag_cycle(1'b1, 1'b0, 6'd5, '0, 4'h0);
    checks++;
    if (tag_bus.RW0_rdata !== 88'h0) begin
      failures++;
      $display("FAIL reset_clears_rdata got=%h exp=%h", tag_bus.RW0_rdata, 88'h0);
    end
    reset = 1'b0;
    tag_cycle(1'b1, 1'b0, 6'd5, '0, 4'h0);
    checks++;
    if (tag_bus.RW0_rdata !== row5) begin
      failures++;
      $display("FAIL mem_survives_reset got=%h exp=%h", tag_bus.RW0_rdata, row5);
    end
    tag_cycle(1'b1, 1'b0, 6'd9, '0, 4'h0);
    checks++;
    if (tag_bus.RW0_rdata !== {88{1'b1}}) begin
      failures++;
      $display("FAIL write_before_reset got=%h exp=%h", tag_bus.RW0_rdata, {88{1'b1}});
    end
  endtask

  task automatic test_data_cfg;
    data_cycle(1'b1, 1'b1, 9'd511, {{31{8'hFF}}, 8'hA5}, 32'h0000_0001);
    data_cycle(1'b1, 1'b0, 9'd511, '0, 32'h0);
    checks++;
    if (data_bus.RW0_rdata[7:0] !== 8'hA5) begin
      failures++;
      $display("FAIL data_byte0 got=%h exp=%h", data_bus.RW0_rdata[7:0], 8'hA5);
    end
    data_cycle(1'b1, 1'b1, 9'd511, {8'h3C, {31{8'h77}}}, 32'h8000_0000);
    data_cycle(1'b1, 1'b0, 9'd511, '0, 32'h0);
    checks++;
    if (data_bus.RW0_rdata[255:248] !== 8'h3C || data_bus.RW0_rdata[7:0] !== 8'hA5) begin
      failures++;
      $display("FAIL data_byte31 got=%h/%h exp=3c/a5",
               data_bus.RW0_rdata[255:248], data_bus.RW0_rdata[7:0]);
    end
  endtask

`ifdef DCACHE_SRAM_ZERO_INIT_EN
  task automatic test_zero_init;
    tag_cycle(1'b1, 1'b0, 6'd10, '0, 4'h0);
    checks++;
    if (tag_bus.RW0_rdata !== 88'h0) begin
      failures++;
      $display("FAIL zero_init_read got=%h exp=%h", tag_bus.RW0_rdata, 88'h0);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    tag_bus.RW0_en     = 1'b0;
    tag_bus.RW0_wmode  = 1'b0;
    tag_bus.RW0_addr   = '0;
    tag_bus.RW0_wdata  = '0;
    tag_bus.RW0_wmask  = '0;
    data_bus.RW0_en    = 1'b0;
    data_bus.RW0_wmode = 1'b0;
    data_bus.RW0_addr  = '0;
    data_bus.RW0_wdata = '0;
    data_bus.RW0_wmask = '0;
    test_reset();
`ifdef DCACHE_SRAM_ZERO_INIT_EN
    test_zero_init();
`endif
    test_full_write();
    test_masked_write();
    test_backdoor();
    test_back_to_back();
    test_hold_and_reset();
    test_data_cfg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
